host_reg_bridge: RTL
====================

Name: host_reg_bridge

Overview:
- Byte-stream command decoder between the host link (UART/SPI byte FIFO) and the accelerator configuration/status register bank.
- Parses host frames into single-cycle, one-hot register write strobes with 16-bit data.
- Returns register read-back values as two response bytes.
- Guarantees framing: bad addresses, read-only writes and stalled frames are flagged and never strobe.

Parameters:
- NumRegs, 10, number of register slots, addresses 0..NumRegs-1 (0x0 version, 0x1 hwid, 0x2 memup ... 0x9 status); max 16.
- ReadOnlyMask, 16'h0003, bit n=1 marks address n read-only (version, hwid).
- TimeoutCycles, 1024, max idle cycles between bytes of a write frame; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- rx_data_i  in  8  host byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  bridge accepts byte; transfer when rx_valid_i & rx_ready_o.
- tx_data_o  out  8  response byte.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  host consumes byte; transfer when tx_valid_o & tx_ready_i.
- reg_wdata_o  out  16  write data to register bank.
- reg_we_o  out  NumRegs  one-hot write strobe, bit n = address n.
- reg_rdata_i  in  NumRegs*16  flattened read-back; address n at [16n+15:16n].
- err_o  out  1  one-cycle error pulse.
- err_code_o  out  2  last error: 0 none, 1 write to read-only, 2 address >= NumRegs, 3 timeout.
- busy_o  out  1  high when state != IDLE.

Behaviour:
- Frame format: command byte = {rw, 3'b reserved (ignored), addr[3:0]}.
  - rw=1 (write): two further bytes, data[15:8] then data[7:0].
  - rw=0 (read): bridge responds with data[15:8] then data[7:0] on tx.
- States: IDLE, WR_HI, WR_LO, STROBE, RD_HI, RD_LO.
- IDLE: rx_ready_o=1. On accepted byte: rw=1 -> WR_HI; rw=0 -> RD_HI.
  - A read latches the reg_rdata_i slice for addr into a 16-bit snapshot on that same edge; out-of-range reads snapshot 16'h0000.
- WR_HI: rx_ready_o=1; accepted byte -> wdata[15:8], go WR_LO.
- WR_LO: rx_ready_o=1; accepted byte -> wdata[7:0], go STROBE.
- STROBE: exactly one cycle; rx_ready_o=0; next state IDLE.
  - Valid writable address: reg_we_o[addr]=1, reg_wdata_o=wdata.
  - Read-only address: no strobe, err_o=1, err_code_o=1.
  - Address >= NumRegs: no strobe, err_o=1, err_code_o=2.
- Write latency: STROBE is the cycle after the low data byte is accepted.
- RD_HI: rx_ready_o=0, tx_valid_o=1, tx_data_o=snapshot[15:8]; on tx transfer -> RD_LO.
- RD_LO: tx_data_o=snapshot[7:0]; on tx transfer -> IDLE.
  - Out-of-range read pulses err_o with code 2 in the cycle the RD_LO byte transfers.
- Read latency: tx_valid_o rises the cycle after the command byte is accepted.
- tx_data_o and tx_valid_o stay stable while tx_ready_i=0; there is no tx timeout.
- Timeout (only when TimeoutCycles>0):
  - An idle counter clears on every accepted rx byte and increments each cycle in WR_HI/WR_LO.
  - When the counter reaches TimeoutCycles: go to IDLE, discard the partial frame, err_o=1, err_code_o=3, no strobe.
- Registered outputs; reg_we_o is zero in every state except STROBE.
- err_code_o holds its value until the next error.
- Reset (any state, mid-frame included): state IDLE, rx_ready_o=1, tx_valid_o=0, tx_data_o=0, reg_we_o=0, reg_wdata_o=0, err_o=0, err_code_o=0, busy_o=0, counter and snapshot 0. A partial frame is lost.
- Reserved bits: ignored. Address field is 4 bits, so addresses 10..15 are out of range when NumRegs=10.

Test Plan:
- Write frame 0x83,0x12,0x34 at one byte/cycle -> the cycle after 0x34 is accepted, reg_we_o=0x008 and reg_wdata_o=0x1234 for exactly one cycle; err_o stays 0.
- reg_rdata_i slot 5 = 0xA5C3, send 0x05 with tx_ready_i=0 for 10 cycles then 1 -> tx holds 0xA5 stable, then emits 0xA5 then 0xC3; rx_ready_o=0 throughout; busy_o falls after 0xC3 transfers.
- Write frame 0x81,0xFF,0xFF -> reg_we_o stays 0; err_o pulses once with err_code_o=1. Then frame 0x8C,0,0 -> err_code_o=2, no strobe.
- TimeoutCycles=8: send 0x82,0x11, then idle 8 cycles -> err_code_o=3 pulse, back to IDLE. Following 0x82,0x00,0x07 -> reg_we_o=0x004, reg_wdata_o=0x0007.
- Assert rst_i asynchronously between the two data bytes of 0x86,0xAB,... -> no strobe, all outputs at reset values immediately. Next full frame 0x86,0x00,0x01 strobes reg_we_o=0x040.
- Back-to-back: write 0x82,0x00,0x05 immediately followed by read 0x02 -> strobe, then tx returns 0x00,0x05 after the bench models the register update.

Source files
------------

// File: rtl/host_reg_bridge.sv
// Host byte-stream command decoder: parses {rw,rsv,addr} frames into one-hot
// register write strobes and returns register read-back as two response bytes.
module host_reg_bridge #(
  parameter int unsigned NumRegs       = 10,
  parameter logic [15:0] ReadOnlyMask  = 16'h0003,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [15:0]             reg_wdata_o,
  output logic [NumRegs-1:0]      reg_we_o,
  input  logic [NumRegs*16-1:0]   reg_rdata_i,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output logic                    busy_o
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = CntW'(TimeoutCycles);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_HI  = 3'd1,
    WR_LO  = 3'd2,
    STROBE = 3'd3,
    RD_HI  = 3'd4,
    RD_LO  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          addr_q, addr_d;
  logic [7:0]          whi_q, whi_d;
  logic [15:0]         snap_q, snap_d;
  logic                rd_oor_q, rd_oor_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumRegs-1:0]  we_q, we_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic                rx_fire;
  logic                rd_err;
  logic                timeout_hit;
  logic [CntW-1:0]     cnt_inc;

  function automatic logic addr_in_range(input logic [3:0] a);
    return {28'd0, a} < 32'(NumRegs);
  endfunction

  function automatic logic [15:0] rd_slice(input logic [3:0] a,
                                           input logic [NumRegs*16-1:0] bus);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < int'(NumRegs); i++) begin
      if (a == 4'(i)) v = bus[16*i +: 16];
    end
    return v;
  endfunction

  function automatic logic [NumRegs-1:0] onehot(input logic [3:0] a);
    logic [NumRegs-1:0] v;
    for (int i = 0; i < int'(NumRegs); i++) begin
      v[i] = (a == 4'(i));
    end
    return v;
  endfunction

  assign rx_ready_o = (state_q == IDLE) || (state_q == WR_HI) || (state_q == WR_LO);
  assign tx_valid_o = (state_q == RD_HI) || (state_q == RD_LO);
  assign busy_o     = (state_q != IDLE);
  assign rx_fire    = rx_valid_i & rx_ready_o;

  // The out-of-range read error must coincide with the low byte transfer,
  // so it bypasses the error register for that one cycle.
  assign rd_err     = (state_q == RD_LO) && tx_ready_i && rd_oor_q;
  assign err_o      = err_q | rd_err;
  assign err_code_o = rd_err ? 2'd2 : err_code_q;

  assign cnt_inc     = cnt_q + CntW'(1);
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_inc == CntLimit);

  assign reg_we_o    = we_q;
  assign reg_wdata_o = wdata_q;

  always_comb begin
    tx_data_o = 8'h00;
    if (state_q == RD_HI)      tx_data_o = snap_q[15:8];
    else if (state_q == RD_LO) tx_data_o = snap_q[7:0];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    whi_d      = whi_q;
    snap_d     = snap_q;
    rd_oor_d   = rd_oor_q;
    cnt_d      = cnt_q;
    we_d       = '0;
    wdata_d    = wdata_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_fire) begin
          addr_d = rx_data_i[3:0];
          if (rx_data_i[7]) begin
            state_d = WR_HI;
          end else begin
            state_d  = RD_HI;
            snap_d   = rd_slice(rx_data_i[3:0], reg_rdata_i);
            rd_oor_d = !addr_in_range(rx_data_i[3:0]);
          end
        end
      end
      WR_HI: begin
        if (rx_fire) begin
          whi_d   = rx_data_i;
          cnt_d   = '0;
          state_d = WR_LO;
        end else if (timeout_hit) begin
          state_d    = IDLE;
          cnt_d      = '0;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR_LO: begin
        if (rx_fire) begin
          cnt_d   = '0;
          state_d = STROBE;
          // Strobe and error flops are loaded here so they show up during STROBE.
          if (!addr_in_range(addr_q)) begin
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else if (ReadOnlyMask[addr_q]) begin
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            we_d    = onehot(addr_q);
            wdata_d = {whi_q, rx_data_i};
          end
        end else if (timeout_hit) begin
          state_d    = IDLE;
          cnt_d      = '0;
          err_d      = 1'b1;
          err_code_d = 2'd3;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STROBE: begin
        state_d = IDLE;
      end
      RD_HI: begin
        if (tx_ready_i) state_d = RD_LO;
      end
      RD_LO: begin
        if (tx_ready_i) begin
          state_d = IDLE;
          if (rd_oor_q) err_code_d = 2'd2;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      whi_q      <= '0;
      snap_q     <= '0;
      rd_oor_q   <= 1'b0;
      cnt_q      <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      whi_q      <= whi_d;
      snap_q     <= snap_d;
      rd_oor_q   <= rd_oor_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule
